// File: rtl/rv32_instr_encoder_if.sv
// Handshake bundle for rv32_instr_encoder.
//   slave  : encoder side (takes field sets, drives encoded words)
//   master : producer/consumer side (testbench, loader)
// Signals:
//   in_valid/in_ready           field-set handshake
//   in_instr                    {funct3, opcode} selector
//   in_rd/in_rs1/in_rs2         register indices
//   in_imm                      immediate (signed offset or value)
//   in_alt                      funct7[5] for SUB/SRA/SRAI
//   addr_load/addr_value        address counter reload
//   out_valid/out_ready         output handshake
//   out_word/out_addr/out_err   encoded word, imem byte address, error flag
interface rv32_instr_encoder_if;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 10;
  localparam int unsigned REG_W   = 5;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [REG_W-1:0]   in_rd;
  logic [REG_W-1:0]   in_rs1;
  logic [REG_W-1:0]   in_rs2;
  logic [XLEN-1:0]    in_imm;
  logic               in_alt;
  logic               addr_load;
  logic [XLEN-1:0]    addr_value;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_word;
  logic [XLEN-1:0]    out_addr;
  logic               out_err;

  modport master (
    output in_valid, in_instr, in_rd, in_rs1, in_rs2, in_imm, in_alt,
    output addr_load, addr_value, out_ready,
    input  in_ready, out_valid, out_word, out_addr, out_err
  );

  modport slave (
    input  in_valid, in_instr, in_rd, in_rs1, in_rs2, in_imm, in_alt,
    input  addr_load, addr_value, out_ready,
    output in_ready, out_valid, out_word, out_addr, out_err
  );
endinterface

// File: rtl/rv32_instr_encoder.sv
// rv32_instr_encoder: packs RV32I field sets into 32-bit instruction words,
// buffers them in a 2-entry FIFO and tags each with a sequential imem address.
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   bus        rv32_instr_encoder_if.slave (input fields, address reload,
//              encoded output word/address/error with valid/ready)
// Parameters:
//   BASE_ADDR  address given to the first word after reset
// Build option:
//   RV32_ENC_RANGE_CHECK_EN  when defined, out-of-range immediates also raise
//                            out_err (the word is still emitted, truncated)
module rv32_instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic              clk,
  input logic              rst,
  rv32_instr_encoder_if.slave bus
);
  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_NONE, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_e;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_e;

  logic [2:0]      f3;
  logic [6:0]      opc;
  logic [XLEN-1:0] imm;
  logic [4:0]      rd, rs1, rs2;

  assign f3  = bus.in_instr[9:7];
  assign opc = bus.in_instr[6:0];
  assign imm = bus.in_imm;
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;

  fmt_e            fmt_c;
  logic            alt_ok_c;
  logic            alt_c;
  logic            range_err_c;
  logic [XLEN-1:0] enc_word_c;
  logic            enc_err_c;

  // Classify: U/J types on opcode alone, everything else needs a legal funct3.
  always_comb begin : classify
    fmt_c    = FMT_NONE;
    alt_ok_c = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC: fmt_c = FMT_U;
      OPC_JAL:            fmt_c = FMT_J;
      OPC_JALR:   if (f3 == 3'b000) fmt_c = FMT_I;
      OPC_BRANCH: if (f3 != 3'b010 && f3 != 3'b011) fmt_c = FMT_B;
      OPC_LOAD:   if (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) fmt_c = FMT_I;
      OPC_STORE:  if (f3 inside {3'b000, 3'b001, 3'b010}) fmt_c = FMT_S;
      OPC_OP_IMM: begin
        if (f3 == 3'b001) begin
          fmt_c = FMT_SH;
        end else if (f3 == 3'b101) begin
          fmt_c    = FMT_SH;
          alt_ok_c = 1'b1;
        end else begin
          fmt_c = FMT_I;
        end
      end
      OPC_OP: begin
        fmt_c    = FMT_R;
        alt_ok_c = (f3 == 3'b000) || (f3 == 3'b101);
      end
      default: fmt_c = FMT_NONE;
    endcase
  end

  // An illegal alt request is flagged but never leaks into the word.
  assign alt_c = bus.in_alt & alt_ok_c;

  always_comb begin : encode
    enc_word_c = '0;
    case (fmt_c)
      FMT_R:  enc_word_c = {1'b0, alt_c, 5'b0, rs2, rs1, f3, rd, opc};
      FMT_I:  enc_word_c = {imm[11:0], rs1, f3, rd, opc};
      FMT_SH: enc_word_c = {1'b0, alt_c, 5'b0, imm[4:0], rs1, f3, rd, opc};
      FMT_S:  enc_word_c = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
      FMT_B:  enc_word_c = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
      FMT_U:  enc_word_c = {imm[31:12], rd, opc};
      FMT_J:  enc_word_c = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
      default: enc_word_c = '0;
    endcase
  end

`ifdef RV32_ENC_RANGE_CHECK_EN
  // In range means the immediate equals the sign extension of its encoded bits.
  always_comb begin : range_check
    range_err_c = 1'b0;
    case (fmt_c)
      FMT_I, FMT_S: range_err_c = (imm != {{20{imm[11]}}, imm[11:0]});
      FMT_B:        range_err_c = (imm != {{19{imm[12]}}, imm[12:0]}) | imm[0];
      FMT_J:        range_err_c = (imm != {{11{imm[20]}}, imm[20:0]}) | imm[0];
      FMT_SH:       range_err_c = |imm[31:5];
      FMT_U:        range_err_c = |imm[11:0];
      default:      range_err_c = 1'b0;
    endcase
  end
`else
  assign range_err_c = 1'b0;
`endif

  assign enc_err_c = (fmt_c == FMT_NONE) | (bus.in_alt & ~alt_ok_c) | range_err_c;

  // FIFO: head register drives out_* directly, tail holds the second entry.
  state_e          state_q, state_d;
  logic            in_ready_q, out_valid_q;
  logic [XLEN-1:0] head_word_q, head_addr_q, tail_word_q, tail_addr_q;
  logic            head_err_q, tail_err_q;
  logic [XLEN-1:0] addr_q, addr_d, cap_addr_c;
  logic            push_c, pop_c;
  logic            load_head_c, load_tail_c, shift_c;

  assign push_c = bus.in_valid & in_ready_q;
  assign pop_c  = out_valid_q & bus.out_ready;

  // Address captured by a push; a same-cycle reload takes priority.
  assign cap_addr_c = bus.addr_load ? bus.addr_value : addr_q;
  assign addr_d     = push_c ? cap_addr_c + 32'd4 : cap_addr_c;

  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Occupancy transitions and which storage register loads this cycle.
  always_comb begin : next_state
    state_d     = state_q;
    load_head_c = 1'b0;
    load_tail_c = 1'b0;
    shift_c     = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (push_c) begin
          state_d     = S_ONE;
          load_head_c = 1'b1;
        end
      end
      S_ONE: begin
        if (push_c && pop_c) begin
          load_head_c = 1'b1;
        end else if (push_c) begin
          state_d     = S_FULL;
          load_tail_c = 1'b1;
        end else if (pop_c) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (pop_c) begin
          state_d = S_ONE;
          shift_c = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin : data_regs
    if (rst) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_word_q <= '0;
      head_addr_q <= '0;
      head_err_q  <= 1'b0;
      tail_word_q <= '0;
      tail_addr_q <= '0;
      tail_err_q  <= 1'b0;
      addr_q      <= BASE_ADDR;
    end else begin
      in_ready_q  <= (state_d != S_FULL);
      out_valid_q <= (state_d != S_EMPTY);
      addr_q      <= addr_d;
      if (load_head_c) begin
        head_word_q <= enc_word_c;
        head_addr_q <= cap_addr_c;
        head_err_q  <= enc_err_c;
      end else if (shift_c) begin
        head_word_q <= tail_word_q;
        head_addr_q <= tail_addr_q;
        head_err_q  <= tail_err_q;
      end
      if (load_tail_c) begin
        tail_word_q <= enc_word_c;
        tail_addr_q <= cap_addr_c;
        tail_err_q  <= enc_err_c;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_word  = head_word_q;
  assign bus.out_addr  = head_addr_q;
  assign bus.out_err   = head_err_q;
endmodule
